// File: rtl/piso_serializer_tx.sv
// Parallel-in serial-out transmitter: valid/ready word intake, one bit per clock, frame markers.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             sout_o,
  output logic             sout_valid_o,
  output logic             frame_start_o,
  output logic             done_o
);

  localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             shreg_out;
  logic             last_bit;
  logic             accept;

  assign shreg_out = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shifted   = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  assign last_bit  = (state_q == StShift) && (cnt_q == LastCnt);

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;

  assign done_o = (state_q == StParity);
  assign sout_o = (state_q == StShift)  ? shreg_out :
                  (state_q == StParity) ? parity_q  : 1'b0;
`else
  assign done_o = last_bit;
  assign sout_o = (state_q == StShift) & shreg_out;
`endif

  assign sout_valid_o  = (state_q != StIdle);
  assign frame_start_o = (state_q == StShift) && (cnt_q == '0);
  // Ready in the final bit cycle lets the next word follow with no gap.
  assign din_ready_o   = (state_q == StIdle) || done_o;
  assign accept        = din_valid_i && din_ready_o;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        state_d = accept ? StShift : StIdle;
      end
      StShift: begin
        shreg_d = shifted;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d = StParity;
`else
          state_d = accept ? StShift : StIdle;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      StParity: begin
        state_d = accept ? StShift : StIdle;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      shreg_d  = din_i;
      cnt_d    = '0;
`ifdef PISO_PARITY_EN
      parity_d = ^din_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer_tx.sv
// Bench for piso_serializer_tx: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue of expected serial bits built from each accepted word.
module tb_piso_serializer_tx;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic fs;
    logic dn;
  } rec_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         m_ready, m_sout, m_valid, m_fs, m_done;
  logic         l_ready, l_sout, l_valid, l_fs, l_done;

  int   vectors = 0;
  int   errors  = 0;
  logic accepted;
  rec_t qm[$];
  rec_t ql[$];

  piso_serializer_tx #(
    .WIDTH    (W),
    .MSB_FIRST(1)
  ) u_msb (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .din_ready_o  (m_ready),
    .sout_o       (m_sout),
    .sout_valid_o (m_valid),
    .frame_start_o(m_fs),
    .done_o       (m_done)
  );

  piso_serializer_tx #(
    .WIDTH    (W),
    .MSB_FIRST(0)
  ) u_lsb (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .din_ready_o  (l_ready),
    .sout_o       (l_sout),
    .sout_valid_o (l_valid),
    .frame_start_o(l_fs),
    .done_o       (l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Expected frame: WIDTH data bits in wire order, then the parity bit when enabled.
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back('{b: w[W-1-i], fs: (i == 0), dn: (i == W - 1) && !Par});
      ql.push_back('{b: w[i],     fs: (i == 0), dn: (i == W - 1) && !Par});
    end
    if (Par) begin
      qm.push_back('{b: ^w, fs: 1'b0, dn: 1'b1});
      ql.push_back('{b: ^w, fs: 1'b0, dn: 1'b1});
    end
  endtask

  task automatic check_cycle();
    rec_t em;
    rec_t el;
    logic busy;
    busy = (qm.size() != 0);
    em   = '0;
    el   = '0;
    if (busy) begin
      em = qm[0];
      el = ql[0];
    end
    chk("msb_valid", m_valid, busy);
    chk("msb_sout",  m_sout,  em.b);
    chk("msb_fs",    m_fs,    em.fs);
    chk("msb_done",  m_done,  em.dn);
    chk("msb_ready", m_ready, !busy || em.dn);
    chk("lsb_valid", l_valid, busy);
    chk("lsb_sout",  l_sout,  el.b);
    chk("lsb_fs",    l_fs,    el.fs);
    chk("lsb_done",  l_done,  el.dn);
    chk("lsb_ready", l_ready, !busy || el.dn);
  endtask

  // One clock: decide acceptance from the model, advance it, then check at the falling edge.
  task automatic tick();
    logic         acc;
    logic [W-1:0] w;
    acc = rst_n && din_valid;
    if (qm.size() != 0) acc = acc && qm[0].dn;
    w = din;
    @(posedge clk);
    if (qm.size() != 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (acc) push_word(w);
    accepted = acc;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic send(input logic [W-1:0] w);
    din       = w;
    din_valid = 1'b1;
    accepted  = 1'b0;
    for (int n = 0; n < 40 && !accepted; n++) tick();
    chk("send_accept", accepted, 1'b1);
    din_valid = 1'b0;
    din       = W'($urandom);
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    accepted  = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    send(8'hA5);
    repeat (11) tick();

    send(8'h3C);
    send(8'hC3);
    repeat (11) tick();

    // Offered words while busy must not disturb the frame in flight.
    send(8'h00);
    tick();
    din       = 8'hFF;
    din_valid = 1'b1;
    repeat (5) tick();
    din_valid = 1'b0;
    repeat (6) tick();

    send(8'h5A);
    repeat (3) tick();
    #1 rst_n = 1'b0;
    qm.delete();
    ql.delete();
    #1 check_cycle();
    @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
    send(8'h96);
    repeat (11) tick();

    send(8'h07);
    repeat (11) tick();
    send(8'h03);
    repeat (11) tick();

    for (int i = 0; i < 300; i++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    din_valid = 1'b0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
